md_sequencer: RTL and testbench
===============================

# md_sequencer

Multiply/divide sequencer for the five-stage MIPS pipeline. It accepts multiply, divide and HI/LO-move operations issued from the Execute stage and owns the HI and LO registers. It runs a fixed-latency busy counter that emulates hardware mult/div delay, and it raises a stall request to the hazard unit whenever a Decode-stage instruction needs the unit while it is occupied.

## Interface
Parameters:
- MULT_CYCLES, default 5: busy cycles for mult/multu (and madd-class ops); legal range 1..15.
- DIV_CYCLES, default 10: busy cycles for div/divu; legal range 1..15.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low reset; while low, all state is cleared.
- e_valid  input  1  Execute stage holds a valid instruction this cycle.
- e_md_op  input  4  operation code, encoding defined in md_pkg.
- e_rs  input  32  forwarded rs operand from Execute.
- e_rt  input  32  forwarded rt operand from Execute.
- d_md_use  input  1  Decode instruction is any MD-class op, including mfhi/mflo/mthi/mtlo.
- start  output  1  combinational; a compute op is accepted this cycle.
- busy  output  1  registered; computation in flight.
- stall_req  output  1  combinational; equals d_md_use & (start | busy).
- hi  output  32  architectural HI register.
- lo  output  32  architectural LO register.

## Operation
- Op codes:
  - 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO.
  - 7 MADD, 8 MADDU, 9 MSUB, 10 MSUBU.
  - 11-15 are treated as NONE.
- States:
  - IDLE: cnt == 0.
  - BUSY: cnt != 0.
  - busy = (cnt != 0).
- Accepting a compute op (IDLE, e_valid, compute op):
  - start = 1.
  - The 64-bit result is computed from e_rs/e_rt and the current {hi,lo} and latched into pend_hi/pend_lo.
  - cnt loads MULT_CYCLES or DIV_CYCLES.
- BUSY: cnt decrements each cycle. On the edge where cnt goes 1 -> 0, hi/lo take pend_hi/pend_lo.
- MTHI/MTLO in IDLE: hi (or lo) takes e_rs on the next edge. busy and start stay 0.
- mfhi/mflo: Execute reads the hi/lo outputs directly. This block has no read port.
- Any op with e_valid in BUSY is a protocol violation, because stall_req prevents it. The op is ignored: no state change, and a simulation assertion fires.
- Arithmetic:
  - MULT: signed 32x32 -> 64 product. MULTU: unsigned.
  - {hi,lo} = product.
  - MADD/MSUB: {hi,lo} ± product, modulo 2^64.
- DIV (signed):
  - Quotient truncates toward zero and goes to lo; remainder takes the dividend's sign and goes to hi.
  - 0x80000000 / 0xFFFFFFFF gives lo = 0x80000000, hi = 0.
- DIVU: unsigned quotient and remainder.
- Divide by zero (either divide op): full DIV_CYCLES busy period, then hi/lo left unchanged.
- Simultaneous events:
  - start and d_md_use in the same cycle: stall_req = 1.
  - Commit edge and d_md_use in the same cycle: stall_req stays 1 in the last busy cycle. The Decode instruction proceeds on the following cycle and sees the new hi/lo.
- Reset low mid-operation: abort immediately; cnt = 0, pending result discarded.

## Timing
- Reset values: hi = 0, lo = 0, busy = 0, cnt = 0, pend_* = 0. start and stall_req are 0 when their inputs are idle.
- Compute op accepted at cycle T:
  - busy is high for cycles T+1 .. T+N (N = configured latency).
  - New hi/lo are visible from T+N+1.
  - A back-to-back op is accepted at T+N+1 at the earliest.
- MTHI/MTLO at cycle T: new value visible at T+1.
- stall_req has zero latency; it is purely combinational from d_md_use, start and busy.

## Configuration
- MD_MADD_EN defined: ops 7-10 are implemented and use MULT_CYCLES.
- MD_MADD_EN undefined: ops 7-10 decode as NONE (start = 0, no state change), and the accumulator adder is not built.

## Structure
- md_pkg holds:
  - MD_OP_W = 4 and the op-code localparams.
  - A cnt width constant of 4.
  - An is_compute/is_div classification function.
- Sub-module md_compute: purely combinational. Takes op, rs, rt, hi, lo; returns res_hi, res_lo and div_by_zero.
- md_sequencer keeps the counter, the pending registers, the HI/LO registers and the stall logic.

## Test plan
- Reset, then MULT rs = 0xFFFFFFFE, rt = 3:
  - start pulses once.
  - busy high for exactly 5 cycles.
  - hi = 0xFFFFFFFF, lo = 0xFFFFFFFA at T+6.
- DIV rs = -7, rt = 2 gives lo = 0xFFFFFFFD, hi = 0xFFFFFFFF after 10 busy cycles. DIVU 7 / 0 leaves hi/lo unchanged.
- d_md_use held high during DIVU: stall_req = 1 from T through T+10 and 0 at T+11. A following MFLO reads the new lo.
- MTHI rs = 0x12345678 in IDLE: hi updates next cycle, busy never asserts. A MULT issued the next cycle is accepted immediately.
- Drive reset low at T+3 of a MULT:
  - busy = 0 and hi = lo = 0 immediately.
  - After release, no commit occurs.
- With MD_MADD_EN and {hi,lo} = 0x0000000100000000, MADD 2*3 gives hi = 1, lo = 6. Without the macro, the same op leaves start = 0 and hi/lo unchanged.

Source files
------------

// File: rtl/md_pkg.sv
// Shared op codes, widths and op classification for the multiply/divide sequencer.
// The MD_MADD_EN macro enables the multiply-accumulate ops (7-10).
package md_pkg;

  localparam int unsigned MD_OP_W  = 4;
  localparam int unsigned MD_CNT_W = 4;

  localparam logic [MD_OP_W-1:0] MD_OP_NONE  = MD_OP_W'(0);
  localparam logic [MD_OP_W-1:0] MD_OP_MULT  = MD_OP_W'(1);
  localparam logic [MD_OP_W-1:0] MD_OP_MULTU = MD_OP_W'(2);
  localparam logic [MD_OP_W-1:0] MD_OP_DIV   = MD_OP_W'(3);
  localparam logic [MD_OP_W-1:0] MD_OP_DIVU  = MD_OP_W'(4);
  localparam logic [MD_OP_W-1:0] MD_OP_MTHI  = MD_OP_W'(5);
  localparam logic [MD_OP_W-1:0] MD_OP_MTLO  = MD_OP_W'(6);
  localparam logic [MD_OP_W-1:0] MD_OP_MADD  = MD_OP_W'(7);
  localparam logic [MD_OP_W-1:0] MD_OP_MADDU = MD_OP_W'(8);
  localparam logic [MD_OP_W-1:0] MD_OP_MSUB  = MD_OP_W'(9);
  localparam logic [MD_OP_W-1:0] MD_OP_MSUBU = MD_OP_W'(10);

  // Ops that occupy the unit for a busy period
  function automatic logic is_compute(input logic [MD_OP_W-1:0] op);
    logic r;
    r = 1'b0;
    case (op)
      MD_OP_NONE, MD_OP_MTHI, MD_OP_MTLO: r = 1'b0;
      MD_OP_MULT, MD_OP_MULTU, MD_OP_DIV, MD_OP_DIVU: r = 1'b1;
`ifdef MD_MADD_EN
      MD_OP_MADD, MD_OP_MADDU, MD_OP_MSUB, MD_OP_MSUBU: r = 1'b1;
`else
      MD_OP_MADD, MD_OP_MADDU, MD_OP_MSUB, MD_OP_MSUBU: r = 1'b0;
`endif
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // Divide ops use the longer latency and have a divide-by-zero case
  function automatic logic is_div(input logic [MD_OP_W-1:0] op);
    return (op == MD_OP_DIV) || (op == MD_OP_DIVU);
  endfunction

endpackage

// File: rtl/md_compute.sv
// Combinational 64-bit result generator for mult/div/accumulate ops.
// Accumulate ops are only built when MD_MADD_EN is defined.
module md_compute
  import md_pkg::*;
(
  input  logic [MD_OP_W-1:0] op,
  input  logic [31:0]        rs,
  input  logic [31:0]        rt,
  input  logic [31:0]        hi,
  input  logic [31:0]        lo,
  output logic [31:0]        res_hi,
  output logic [31:0]        res_lo,
  output logic               div_by_zero
);

  logic        signed_op;
  logic [63:0] rs_x;
  logic [63:0] rt_x;
  logic [63:0] prod;
  logic [31:0] rs_mag;
  logic [31:0] rt_mag;
  logic [31:0] den;
  logic [31:0] quo_mag;
  logic [31:0] rem_mag;
  logic [31:0] quo;
  logic [31:0] rem;

  // Operand extension, product and sign-magnitude division
  always_comb begin
    signed_op = (op == MD_OP_MULT) || (op == MD_OP_DIV) ||
                (op == MD_OP_MADD) || (op == MD_OP_MSUB);
    rs_x      = signed_op ? {{32{rs[31]}}, rs} : {32'd0, rs};
    rt_x      = signed_op ? {{32{rt[31]}}, rt} : {32'd0, rt};
    prod      = rs_x * rt_x;

    // Magnitudes wrap correctly for 0x80000000, so the overflow case needs no special path
    rs_mag  = (signed_op && rs[31]) ? (~rs + 32'd1) : rs;
    rt_mag  = (signed_op && rt[31]) ? (~rt + 32'd1) : rt;
    den     = (rt_mag == 32'd0) ? 32'd1 : rt_mag;
    quo_mag = rs_mag / den;
    rem_mag = rs_mag % den;
    quo     = (signed_op && (rs[31] ^ rt[31])) ? (~quo_mag + 32'd1) : quo_mag;
    rem     = (signed_op && rs[31]) ? (~rem_mag + 32'd1) : rem_mag;

    div_by_zero = is_div(op) && (rt == 32'd0);
  end

  // Result select; non-compute ops reproduce the current HI/LO
  always_comb begin
    {res_hi, res_lo} = {hi, lo};
    case (op)
      MD_OP_MULT, MD_OP_MULTU: {res_hi, res_lo} = prod;
      MD_OP_DIV, MD_OP_DIVU:   {res_hi, res_lo} = div_by_zero ? 64'd0 : {rem, quo};
`ifdef MD_MADD_EN
      MD_OP_MADD, MD_OP_MADDU: {res_hi, res_lo} = {hi, lo} + prod;
      MD_OP_MSUB, MD_OP_MSUBU: {res_hi, res_lo} = {hi, lo} - prod;
`endif
      default: {res_hi, res_lo} = {hi, lo};
    endcase
  end

endmodule

// File: rtl/md_sequencer.sv
// Multiply/divide sequencer: owns HI/LO, emulates fixed mult/div latency and
// raises a Decode stall while the unit is occupied.
// MD_MADD_EN enables the multiply-accumulate ops.
module md_sequencer
  import md_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               e_valid,
  input  logic [MD_OP_W-1:0] e_md_op,
  input  logic [31:0]        e_rs,
  input  logic [31:0]        e_rt,
  input  logic               d_md_use,
  output logic               start,
  output logic               busy,
  output logic               stall_req,
  output logic [31:0]        hi,
  output logic [31:0]        lo
);

  logic [MD_CNT_W-1:0] cnt;
  logic [31:0]         pend_hi;
  logic [31:0]         pend_lo;
  logic [31:0]         res_hi;
  logic [31:0]         res_lo;
  logic                div_by_zero;
  logic                idle;

  md_compute u_compute (
    .op          (e_md_op),
    .rs          (e_rs),
    .rt          (e_rt),
    .hi          (hi),
    .lo          (lo),
    .res_hi      (res_hi),
    .res_lo      (res_lo),
    .div_by_zero (div_by_zero)
  );

  // Accept / stall decode
  always_comb begin
    idle      = (cnt == '0);
    busy      = !idle;
    start     = idle && e_valid && is_compute(e_md_op);
    stall_req = d_md_use && (start || busy);
  end

  // Busy counter, pending result and architectural HI/LO
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      hi      <= '0;
      lo      <= '0;
    end else if (!idle) begin
      cnt <= cnt - MD_CNT_W'(1);
      if (cnt == MD_CNT_W'(1)) begin
        hi <= pend_hi;
        lo <= pend_lo;
      end
    end else if (start) begin
      cnt <= is_div(e_md_op) ? MD_CNT_W'(DIV_CYCLES) : MD_CNT_W'(MULT_CYCLES);
      // A zero divisor commits the current HI/LO back unchanged
      pend_hi <= div_by_zero ? hi : res_hi;
      pend_lo <= div_by_zero ? lo : res_lo;
    end else if (e_valid && (e_md_op == MD_OP_MTHI)) begin
      hi <= e_rs;
    end else if (e_valid && (e_md_op == MD_OP_MTLO)) begin
      lo <= e_rs;
    end
  end

  // MD op issued while busy means the stall was ignored upstream
  always @(posedge clk) begin
    if (reset && busy && e_valid)
      assert (!(is_compute(e_md_op) || e_md_op == MD_OP_MTHI || e_md_op == MD_OP_MTLO))
        else $error("md_sequencer: MD op %0d issued while busy", e_md_op);
  end

endmodule

// File: tb/tb_md_sequencer.sv
// Directed self-checking bench for md_sequencer (default latencies 5/10).
module tb_md_sequencer;
  import md_pkg::*;

  logic               clk;
  logic               reset;
  logic               e_valid;
  logic [MD_OP_W-1:0] e_md_op;
  logic [31:0]        e_rs;
  logic [31:0]        e_rt;
  logic               d_md_use;
  logic               start;
  logic               busy;
  logic               stall_req;
  logic [31:0]        hi;
  logic [31:0]        lo;

  int checks = 0;
  int errors = 0;

  md_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .e_valid   (e_valid),
    .e_md_op   (e_md_op),
    .e_rs      (e_rs),
    .e_rt      (e_rt),
    .d_md_use  (d_md_use),
    .start     (start),
    .busy      (busy),
    .stall_req (stall_req),
    .hi        (hi),
    .lo        (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Present an op for one cycle, let combinational outputs settle
  task automatic issue(input logic [MD_OP_W-1:0] op, input logic [31:0] rs, input logic [31:0] rt);
    cyc();
    e_valid = 1'b1;
    e_md_op = op;
    e_rs    = rs;
    e_rt    = rt;
    #1;
  endtask

  task automatic idle_in();
    e_valid = 1'b0;
    e_md_op = MD_OP_NONE;
    e_rs    = '0;
    e_rt    = '0;
  endtask

  // Run a compute op and check start, busy duration and final HI/LO
  task automatic run_op(input string tag, input logic [MD_OP_W-1:0] op,
                        input logic [31:0] rs, input logic [31:0] rt,
                        input int n, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    logic [31:0] old_hi;
    int          busy_cnt;
    old_hi = hi;
    issue(op, rs, rt);
    chk({tag, " start"}, 64'(start), 64'd1);
    chk({tag, " busy@T"}, 64'(busy), 64'd0);
    busy_cnt = 0;
    for (int i = 0; i < n; i++) begin
      cyc();
      idle_in();
      #1;
      if (busy) busy_cnt++;
      if (i == n - 1) chk({tag, " hi before commit"}, 64'(hi), 64'(old_hi));
    end
    chk({tag, " busy cycles"}, 64'(busy_cnt), 64'(n));
    cyc();
    chk({tag, " busy end"}, 64'(busy), 64'd0);
    chk({tag, " hi"}, 64'(hi), 64'(exp_hi));
    chk({tag, " lo"}, 64'(lo), 64'(exp_lo));
  endtask

  initial begin
    reset    = 1'b0;
    d_md_use = 1'b0;
    idle_in();
    repeat (3) @(posedge clk);
    #1;
    chk("reset hi", 64'(hi), 64'd0);
    chk("reset lo", 64'(lo), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset start", 64'(start), 64'd0);
    chk("reset stall", 64'(stall_req), 64'd0);
    @(negedge clk);
    reset = 1'b1;

    // Signed multiply: -2 * 3
    run_op("mult", MD_OP_MULT, 32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);

    // Signed divide: -7 / 2 -> q=-3, r=-1
    run_op("div", MD_OP_DIV, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    // Signed overflow case
    run_op("div ovf", MD_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0, 32'h8000_0000);

    // Unsigned multiply: 0xFFFFFFFF * 2
    run_op("multu", MD_OP_MULTU, 32'hFFFF_FFFF, 32'd2, 5, 32'h1, 32'hFFFF_FFFE);

    // DIVU 100/7 with Decode waiting: stall T..T+10, released at T+11
    d_md_use = 1'b1;
    issue(MD_OP_DIVU, 32'd100, 32'd7);
    chk("divu stall@T", 64'(stall_req), 64'd1);
    for (int i = 1; i <= 10; i++) begin
      cyc();
      idle_in();
      #1;
      chk($sformatf("divu stall@T+%0d", i), 64'(stall_req), 64'd1);
    end
    cyc();
    chk("divu stall@T+11", 64'(stall_req), 64'd0);
    chk("divu lo (mflo)", 64'(lo), 64'd14);
    chk("divu hi", 64'(hi), 64'd2);
    d_md_use = 1'b0;

    // Divide by zero: full busy period, HI/LO kept
    run_op("divu by 0", MD_OP_DIVU, 32'd7, 32'd0, 10, 32'd2, 32'd14);

    // MTHI in IDLE, then MULT accepted the next cycle
    issue(MD_OP_MTHI, 32'h1234_5678, 32'd0);
    chk("mthi start", 64'(start), 64'd0);
    chk("mthi busy", 64'(busy), 64'd0);
    issue(MD_OP_MULT, 32'h10, 32'h10);
    chk("mthi hi", 64'(hi), 64'h1234_5678);
    chk("mult after mthi start", 64'(start), 64'd1);
    chk("mult after mthi busy", 64'(busy), 64'd0);
    for (int i = 0; i < 5; i++) begin
      cyc();
      idle_in();
    end
    // Back-to-back op accepted at T+N+1
    issue(MD_OP_MULTU, 32'd3, 32'd3);
    chk("b2b start", 64'(start), 64'd1);
    chk("b2b hi", 64'(hi), 64'd0);
    chk("b2b lo", 64'(lo), 64'h100);
    for (int i = 0; i < 5; i++) begin
      cyc();
      idle_in();
    end
    cyc();
    chk("b2b result lo", 64'(lo), 64'd9);

    // Reset mid-operation aborts the pending commit
    issue(MD_OP_MULT, 32'd3, 32'd5);
    cyc();
    idle_in();
    cyc();
    cyc();
    reset = 1'b0;
    #1;
    chk("abort busy", 64'(busy), 64'd0);
    chk("abort hi", 64'(hi), 64'd0);
    chk("abort lo", 64'(lo), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (8) cyc();
    chk("abort no commit busy", 64'(busy), 64'd0);
    chk("abort no commit lo", 64'(lo), 64'd0);

    // Accumulate: {hi,lo} = 0x1_00000000, MADD 2*3
    issue(MD_OP_MTHI, 32'd1, 32'd0);
    issue(MD_OP_MTLO, 32'd0, 32'd0);
`ifdef MD_MADD_EN
    run_op("madd", MD_OP_MADD, 32'd2, 32'd3, 5, 32'd1, 32'd6);
`else
    issue(MD_OP_MADD, 32'd2, 32'd3);
    chk("madd off start", 64'(start), 64'd0);
    cyc();
    idle_in();
    #1;
    chk("madd off busy", 64'(busy), 64'd0);
    repeat (6) cyc();
    chk("madd off hi", 64'(hi), 64'd1);
    chk("madd off lo", 64'(lo), 64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
